w5300_bus_responder: RTL and testbench
======================================

# w5300_bus_responder

Synthesizable W5300-side responder for the 16-bit asynchronous parallel host bus: it answers the chip-select/read/write strobes driven by `w5300_parallel_if`, backs them with a small word register file, and drives `int_n`. It replaces the physical W5300 in on-FPGA loopback builds and simulation benches, so the host interface can be exercised without silicon.

## Interface
- `CLK_FREQ`, 100: clock frequency in MHz; documentation only, no timing derived from it.
- `ADDR_W`, 6: register-file word-index width. The array holds 2^ADDR_W 16-bit words, indexed by `addr[ADDR_W:1]`.
- `clk`  in  1: sole clock, rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `data_in`  in  16: sampled value of the tri-state data bus.
- `data_out`  out  16: read data toward the bus.
- `data_oe`  out  1: bus output enable. The top level drives `data = data_oe ? data_out : 16'hz`.
- `addr`  in  10: byte address from the host. `addr[0]` is ignored (16-bit mode).
- `cs_n`, `rd_n`, `we_n`  in  1 each: host strobes, active low, asynchronous to `clk`.
- `int_n`  out  1: interrupt to the host, active low.
- `irq_set`  in  8: local interrupt sources. A one-cycle pulse on bit k sets IR[k].
- `wr_valid`  out  1: one-cycle pulse when a write commits.
- `wr_addr`  out  10: byte address of the committed write.
- `wr_data`  out  16: data of the committed write.

## Operation
- **Input synchronization**
  - `cs_n`, `rd_n` and `we_n` pass through a 2-FF synchronizer.
  - `addr` and `data_in` pass through an equal-depth 2-stage register, so they stay cycle-aligned with the synced strobes.
- **State machine**
  - S_IDLE:
    - synced `cs_n`=0 and `we_n`=0 → S_WRITE. Write has priority, even if `rd_n` is also low.
    - else synced `cs_n`=0 and `rd_n`=0 → S_READ.
  - S_READ:
    - entry cycle: load `data_out` from the map using the aligned address; set the internal `oe_q`.
    - stay while synced `cs_n`=0 and `rd_n`=0; otherwise clear `oe_q` and go to S_RECOVER.
  - S_WRITE:
    - every cycle, latch the aligned address and data into a holding register.
    - when synced `cs_n` or `we_n` goes high, commit the held values and go to S_RECOVER.
  - S_RECOVER: one cycle; no access is decoded; then S_IDLE.
- **Output enable**
  - `data_oe = oe_q & ~cs_n & ~rd_n`, gated with the raw pins so the bus is released immediately when the host deasserts.
- **Register map** (byte address)
  - 0x002 IR, bits [7:0]:
    - write-1-to-clear.
    - `irq_set` ORs into it every cycle.
    - a set and a clear of the same bit in the same cycle: set wins.
    - bits [15:8] read 0.
  - 0x004 IMR, bits [7:0]: read/write; bits [15:8] read 0.
  - other word indices < 2^ADDR_W: general read/write storage.
  - indices ≥ 2^ADDR_W: reads return 0x0000, writes are discarded. `wr_valid` still pulses for discarded writes.
- **Interrupt**
  - `int_n` is registered: `int_n <= ~|(IR & IMR)`.
- **Reset**
  - state S_IDLE.
  - all registers, IR, IMR and synchronizers cleared; synchronizer strobe stages reset to 1.
  - outputs: `data_oe`=0, `data_out`=0, `int_n`=1, `wr_valid`=0, `wr_addr`=0, `wr_data`=0.
  - a reset during an access aborts it: no commit, bus released.

## Timing
- **Read latency:** `cs_n`/`rd_n` low before clk edge N gives `data_oe`=1 with valid `data_out` after edge N+3. The host read strobe must last ≥ 4 clk.
- **Read release:** `data_oe` falls combinationally when `rd_n` or `cs_n` rises. `data_out` holds until the next read.
- **Write setup/hold:** `addr` and `data_in` must be stable for ≥ 3 edges before the `we_n`/`cs_n` rising edge. The committed value is the last one sampled while both were low.
- **Write commit:** `wr_valid` pulses, and the register updates, on edge R+3 after the strobe rise. `int_n` reflects a changed IR/IMR one cycle after that.
- **Recovery:** minimum gap between accesses is 1 clk of S_RECOVER after the synced deassertion. An access starting earlier is decoded once the gap ends, provided its strobes are still low.
- **`irq_set`:** pulse at edge N → IR bit set at N; `int_n` low at N+1 if the bit is unmasked.

## Configuration
- `W5300_RESP_IDR_EN`
  - defined: byte address 0x3FE is a read-only ID register returning 0x5300. Writes to it are discarded (`wr_valid` still pulses).
  - undefined: 0x3FE is an ordinary address and follows the range rules above.

## Test plan
- **Reset:** assert `rst` mid-read with `data_oe`=1 → `data_oe`=0, `int_n`=1 and `wr_valid`=0 immediately. Afterwards, reads of 0x004 and 0x010 return 0x0000.
- **Write/read:** write 0xA5C3 to 0x010 → `wr_valid` pulse with `wr_addr`=0x010 and `wr_data`=0xA5C3. A subsequent read of 0x010 returns 0xA5C3, with `data_oe` high 3 clk after the strobes fall.
- **Out of range** (ADDR_W=6): write 0x1234 to 0x200 → `wr_valid` pulses. A read of 0x200 returns 0x0000.
- **Interrupt path:**
  - write IMR=0x05, pulse `irq_set`=0x04 → `int_n`=0 next cycle.
  - write IR=0x04 → `int_n`=1 after commit.
  - write-1-clear of bit 2 coinciding with an `irq_set`[2] pulse → bit stays set.
- **Strobe overlap:** `rd_n` and `we_n` low together at 0x012 with data 0x00FF → treated as a write; `data_oe` never asserts; 0x012 reads 0x00FF.
- **ID register:** read 0x3FE → 0x5300 with `W5300_RESP_IDR_EN` defined, 0x0000 without it.

Source files
------------

// File: rtl/w5300_bus_responder.sv
// Purpose: W5300-side responder for the 16-bit async host bus; word register file with IR/IMR and int_n.
// Latency: strobes low before edge N -> data_oe/data_out valid after N+3; write commits on edge R+3 after strobe rise.
// Backpressure: none; the host paces accesses with its strobes, one S_RECOVER cycle separates accesses.
//
// Ports: clk/rst (async active-high); data_in/data_out/data_oe tri-state bus halves; addr (byte, bit 0 ignored);
//        cs_n/rd_n/we_n host strobes (async); int_n interrupt; irq_set local IR sources;
//        wr_valid/wr_addr/wr_data one-cycle commit notification.
// Optional feature: define W5300_RESP_IDR_EN to make byte address 0x3FE a read-only ID register (0x5300).
module w5300_bus_responder #(
    parameter int CLK_FREQ = 100,
    parameter int ADDR_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_oe,
    input  logic [9:0]  addr,
    input  logic        cs_n,
    input  logic        rd_n,
    input  logic        we_n,
    output logic        int_n,
    input  logic [7:0]  irq_set,
    output logic        wr_valid,
    output logic [9:0]  wr_addr,
    output logic [15:0] wr_data
);

    localparam int DEPTH = 1 << ADDR_W;

    // CLK_FREQ is informational; the word index is 9 bits so ADDR_W cannot exceed 9.
    if (ADDR_W < 1 || ADDR_W > 9 || CLK_FREQ < 1) begin : g_param_check
        $error("w5300_bus_responder: unsupported parameter values");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_RECOVER
    } state_t;

    // Synchronizer / alignment stages
    logic        cs_s1_q, cs_s2_q, rd_s1_q, rd_s2_q, we_s1_q, we_s2_q;
    logic [9:0]  addr_s1_q, addr_s2_q;
    logic [15:0] din_s1_q, din_s2_q;

    state_t      state_q, state_d;
    logic        oe_q, oe_d;
    logic [15:0] data_out_q, data_out_d;
    logic [9:0]  hold_addr_q, hold_addr_d;
    logic [15:0] hold_data_q, hold_data_d;
    logic        commit_q, commit_d;
    logic        wr_valid_q, wr_valid_d;
    logic [9:0]  wr_addr_q, wr_addr_d;
    logic [15:0] wr_data_q, wr_data_d;
    logic [7:0]  ir_q, ir_d;
    logic [7:0]  imr_q, imr_d;
    logic        int_n_q, int_n_d;
    logic [15:0] mem_q [DEPTH];
    logic [15:0] mem_d [DEPTH];

    logic        acc_rd, acc_wr;
    logic [8:0]  rd_idx, wr_idx;
    logic        rd_in_range, wr_in_range;
    logic [15:0] rd_word;
    logic [7:0]  ir_clr;

    assign acc_rd = ~cs_s2_q & ~rd_s2_q;
    assign acc_wr = ~cs_s2_q & ~we_s2_q;

    assign rd_idx      = addr_s2_q[9:1];
    assign wr_idx      = hold_addr_q[9:1];
    assign rd_in_range = ({1'b0, rd_idx} < 10'(DEPTH));
    assign wr_in_range = ({1'b0, wr_idx} < 10'(DEPTH));

    // Read decode from the aligned address
    always_comb begin
        rd_word = 16'h0000;
`ifdef W5300_RESP_IDR_EN
        if (rd_idx == 9'h1FF) begin
            rd_word = 16'h5300;
        end else
`endif
        if (rd_idx == 9'd1) begin
            rd_word = {8'h00, ir_q};
        end else if (rd_idx == 9'd2) begin
            rd_word = {8'h00, imr_q};
        end else if (rd_in_range) begin
            rd_word = mem_q[rd_idx[ADDR_W-1:0]];
        end
    end

    always_comb begin
        state_d     = state_q;
        oe_d        = oe_q;
        data_out_d  = data_out_q;
        hold_addr_d = hold_addr_q;
        hold_data_d = hold_data_q;
        commit_d    = 1'b0;
        wr_valid_d  = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        imr_d       = imr_q;
        ir_clr      = 8'h00;
        mem_d       = mem_q;

        case (state_q)
            S_IDLE: begin
                if (acc_wr) begin
                    state_d = S_WRITE;
                end else if (acc_rd) begin
                    state_d = S_READ;
                end
            end
            S_READ: begin
                // oe_q is always clear on the entry cycle, so it marks the one-shot load.
                if (!oe_q) begin
                    data_out_d = rd_word;
                end
                if (acc_rd) begin
                    oe_d = 1'b1;
                end else begin
                    oe_d    = 1'b0;
                    state_d = S_RECOVER;
                end
            end
            S_WRITE: begin
                // Only samples taken while both strobes were low may be committed.
                if (acc_wr) begin
                    hold_addr_d = addr_s2_q;
                    hold_data_d = din_s2_q;
                end else begin
                    commit_d = 1'b1;
                    state_d  = S_RECOVER;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Commit lands on the S_RECOVER -> S_IDLE edge, i.e. R+3 after the strobe rise.
        if (commit_q) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = hold_addr_q;
            wr_data_d  = hold_data_q;
`ifdef W5300_RESP_IDR_EN
            if (wr_idx == 9'h1FF) begin
                // read-only ID: write discarded
            end else
`endif
            if (wr_idx == 9'd1) begin
                ir_clr = hold_data_q[7:0];
            end else if (wr_idx == 9'd2) begin
                imr_d = hold_data_q[7:0];
            end else if (wr_in_range) begin
                mem_d[wr_idx[ADDR_W-1:0]] = hold_data_q;
            end
        end

        // Set after clear so a coincident irq_set pulse wins over write-1-to-clear.
        ir_d    = (ir_q & ~ir_clr) | irq_set;
        int_n_d = ~|(ir_q & imr_q);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cs_s1_q     <= 1'b1;
            cs_s2_q     <= 1'b1;
            rd_s1_q     <= 1'b1;
            rd_s2_q     <= 1'b1;
            we_s1_q     <= 1'b1;
            we_s2_q     <= 1'b1;
            addr_s1_q   <= '0;
            addr_s2_q   <= '0;
            din_s1_q    <= '0;
            din_s2_q    <= '0;
            state_q     <= S_IDLE;
            oe_q        <= 1'b0;
            data_out_q  <= '0;
            hold_addr_q <= '0;
            hold_data_q <= '0;
            commit_q    <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            ir_q        <= '0;
            imr_q       <= '0;
            int_n_q     <= 1'b1;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cs_s1_q     <= cs_n;
            cs_s2_q     <= cs_s1_q;
            rd_s1_q     <= rd_n;
            rd_s2_q     <= rd_s1_q;
            we_s1_q     <= we_n;
            we_s2_q     <= we_s1_q;
            addr_s1_q   <= addr;
            addr_s2_q   <= addr_s1_q;
            din_s1_q    <= data_in;
            din_s2_q    <= din_s1_q;
            state_q     <= state_d;
            oe_q        <= oe_d;
            data_out_q  <= data_out_d;
            hold_addr_q <= hold_addr_d;
            hold_data_q <= hold_data_d;
            commit_q    <= commit_d;
            wr_valid_q  <= wr_valid_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            ir_q        <= ir_d;
            imr_q       <= imr_d;
            int_n_q     <= int_n_d;
            mem_q       <= mem_d;
        end
    end

    // Raw-pin gating releases the bus as soon as the host lets go, without waiting on the synchronizer.
    assign data_oe  = oe_q & ~cs_n & ~rd_n;
    assign data_out = data_out_q;
    assign int_n    = int_n_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;

endmodule

// File: tb/tb_w5300_bus_responder.sv
// Purpose: self-checking bench for w5300_bus_responder; writes/reads scoreboarded through queues.
// Latency: checks read data at strobe+4 edges and write commit at rise+4 edges (inputs driven 1 time unit after an edge).
// Backpressure: none; host strobes are driven directly, with waits bounded by cycle budgets.
`timescale 1ns/1ps
module tb_w5300_bus_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] data_in;
    logic [15:0] data_out;
    logic        data_oe;
    logic [9:0]  addr;
    logic        cs_n, rd_n, we_n;
    logic        int_n;
    logic [7:0]  irq_set;
    logic        wr_valid;
    logic [9:0]  wr_addr;
    logic [15:0] wr_data;

    int vecs = 0;
    int errs = 0;

    logic [25:0] wq [$];
    logic [15:0] rq [$];
    logic [25:0] mon_exp;

`ifdef W5300_RESP_IDR_EN
    localparam logic [15:0] ID_EXP = 16'h5300;
`else
    localparam logic [15:0] ID_EXP = 16'h0000;
`endif

    w5300_bus_responder #(.CLK_FREQ(100), .ADDR_W(6)) dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (data_out),
        .data_oe  (data_oe),
        .addr     (addr),
        .cs_n     (cs_n),
        .rd_n     (rd_n),
        .we_n     (we_n),
        .int_n    (int_n),
        .irq_set  (irq_set),
        .wr_valid (wr_valid),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Write scoreboard: every commit pulse must match the oldest pending write.
    always @(posedge clk) begin
        #1;
        if (rst === 1'b0 && wr_valid === 1'b1) begin
            vecs++;
            if (wq.size() == 0) begin
                errs++;
                $display("FAIL wr_unexpected: got addr=%h data=%h, none expected", wr_addr, wr_data);
            end else begin
                mon_exp = wq.pop_front();
                if ({wr_addr, wr_data} !== mon_exp) begin
                    errs++;
                    $display("FAIL wr_commit: got addr=%h data=%h, expected addr=%h data=%h",
                             wr_addr, wr_data, mon_exp[25:16], mon_exp[15:0]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic host_write(input logic [9:0] a, input logic [15:0] d,
                              input logic [7:0] irq_c, input bit with_rd);
        int  n;
        bit  seen;
        bit  oe_seen;
        wq.push_back({a, d});
        addr    = a;
        data_in = d;
        cs_n    = 1'b0;
        we_n    = 1'b0;
        rd_n    = with_rd ? 1'b0 : 1'b1;
        oe_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            if (data_oe !== 1'b0) oe_seen = 1'b1;
        end
        cs_n = 1'b1;
        we_n = 1'b1;
        rd_n = 1'b1;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 10) begin
            if (n == 3) irq_set = irq_c;
            tick;
            irq_set = 8'h00;
            n++;
            if (wr_valid === 1'b1) seen = 1'b1;
        end
        vecs++;
        if (!seen || n != 4) begin
            errs++;
            $display("FAIL wr_latency addr=%h: got %0d edges (seen=%0d), expected 4", a, n, seen);
        end
        tick;
        vecs++;
        if (wr_valid !== 1'b0) begin
            errs++;
            $display("FAIL wr_pulse_width addr=%h: wr_valid=%b, expected 0", a, wr_valid);
        end
        if (with_rd) begin
            vecs++;
            if (oe_seen) begin
                errs++;
                $display("FAIL overlap_oe addr=%h: data_oe asserted, expected 0", a);
            end
        end
    endtask

    task automatic host_read(input logic [9:0] a, input logic [15:0] exp);
        logic [15:0] e;
        rq.push_back(exp);
        addr = a;
        cs_n = 1'b0;
        rd_n = 1'b0;
        repeat (3) tick;
        vecs++;
        if (data_oe !== 1'b0) begin
            errs++;
            $display("FAIL rd_oe_early addr=%h: data_oe=%b, expected 0", a, data_oe);
        end
        tick;
        vecs++;
        if (data_oe !== 1'b1) begin
            errs++;
            $display("FAIL rd_oe addr=%h: data_oe=%b, expected 1", a, data_oe);
        end
        e = rq.pop_front();
        vecs++;
        if (data_out !== e) begin
            errs++;
            $display("FAIL rd_data addr=%h: got %h, expected %h", a, data_out, e);
        end
        tick;
        cs_n = 1'b1;
        rd_n = 1'b1;
        #1;
        vecs++;
        if (data_oe !== 1'b0) begin
            errs++;
            $display("FAIL rd_release addr=%h: data_oe=%b, expected 0", a, data_oe);
        end
        repeat (3) tick;
    endtask

    task automatic pulse_irq(input logic [7:0] v, input logic exp_first, input logic exp_second);
        irq_set = v;
        tick;
        irq_set = 8'h00;
        vecs++;
        if (int_n !== exp_first) begin
            errs++;
            $display("FAIL irq_edge_n: int_n=%b, expected %b", int_n, exp_first);
        end
        tick;
        vecs++;
        if (int_n !== exp_second) begin
            errs++;
            $display("FAIL irq_edge_n1: int_n=%b, expected %b", int_n, exp_second);
        end
    endtask

    task automatic test_reset;
        rst     = 1'b1;
        cs_n    = 1'b1;
        rd_n    = 1'b1;
        we_n    = 1'b1;
        addr    = '0;
        data_in = '0;
        irq_set = '0;
        repeat (3) tick;
        vecs++;
        if ({data_oe, data_out, int_n, wr_valid, wr_addr, wr_data} !== {1'b0, 16'h0, 1'b1, 1'b0, 10'h0, 16'h0}) begin
            errs++;
            $display("FAIL reset_values: oe=%b dout=%h int_n=%b wv=%b wa=%h wd=%h, expected 0 0000 1 0 000 0000",
                     data_oe, data_out, int_n, wr_valid, wr_addr, wr_data);
        end
        rst = 1'b0;
        repeat (2) tick;
    endtask

    task automatic test_write_read;
        host_write(10'h010, 16'hA5C3, 8'h00, 1'b0);
        host_read(10'h010, 16'hA5C3);
        host_write(10'h011, 16'h0F0F, 8'h00, 1'b0);   // addr[0] ignored: same word as 0x010
        host_read(10'h010, 16'h0F0F);
        host_write(10'h010, 16'hA5C3, 8'h00, 1'b0);
    endtask

    task automatic test_out_of_range;
        host_write(10'h200, 16'h1234, 8'h00, 1'b0);
        host_read(10'h200, 16'h0000);
        host_write(10'h07E, 16'hBEEF, 8'h00, 1'b0);
        host_read(10'h07E, 16'hBEEF);
        host_write(10'h080, 16'h1111, 8'h00, 1'b0);
        host_read(10'h000, 16'h0000);
    endtask

    task automatic test_interrupt;
        host_write(10'h004, 16'hFF05, 8'h00, 1'b0);
        host_read(10'h004, 16'h0005);
        vecs++;
        if (int_n !== 1'b1) begin
            errs++;
            $display("FAIL int_idle: int_n=%b, expected 1", int_n);
        end
        pulse_irq(8'h04, 1'b1, 1'b0);
        host_read(10'h002, 16'h0004);
        host_write(10'h002, 16'h0004, 8'h00, 1'b0);
        vecs++;
        if (int_n !== 1'b1) begin
            errs++;
            $display("FAIL int_clear: int_n=%b, expected 1", int_n);
        end
        pulse_irq(8'h02, 1'b1, 1'b1);                  // masked source
        host_read(10'h002, 16'h0002);
        pulse_irq(8'h04, 1'b1, 1'b0);
        host_write(10'h002, 16'h0004, 8'h04, 1'b0);    // clear collides with set
        vecs++;
        if (int_n !== 1'b0) begin
            errs++;
            $display("FAIL int_set_wins: int_n=%b, expected 0", int_n);
        end
        host_read(10'h002, 16'h0006);
    endtask

    task automatic test_overlap;
        host_write(10'h012, 16'h00FF, 8'h00, 1'b1);
        host_read(10'h012, 16'h00FF);
    endtask

    task automatic test_id_reg;
        host_read(10'h3FE, ID_EXP);
        host_write(10'h3FE, 16'hFFFF, 8'h00, 1'b0);
        host_read(10'h3FE, ID_EXP);
    endtask

    task automatic test_back_to_back;
        int n;
        wq.push_back({10'h01E, 16'h1357});
        wq.push_back({10'h020, 16'h5A5A});
        addr = 10'h01E; data_in = 16'h1357; cs_n = 1'b0; we_n = 1'b0;
        repeat (5) tick;
        cs_n = 1'b1; we_n = 1'b1;
        tick;
        addr = 10'h020; data_in = 16'h5A5A; cs_n = 1'b0; we_n = 1'b0;
        repeat (5) tick;
        cs_n = 1'b1; we_n = 1'b1;
        n = 0;
        while (wq.size() != 0 && n < 20) begin
            tick;
            n++;
        end
        vecs++;
        if (wq.size() != 0) begin
            errs++;
            $display("FAIL b2b_commits: %0d writes outstanding, expected 0", wq.size());
        end
        tick;
        host_read(10'h01E, 16'h1357);
        host_read(10'h020, 16'h5A5A);
    endtask

    task automatic test_reset_mid_access;
        vecs++;
        if (int_n !== 1'b0) begin
            errs++;
            $display("FAIL pre_reset_int: int_n=%b, expected 0", int_n);
        end
        addr = 10'h010; cs_n = 1'b0; rd_n = 1'b0;
        repeat (4) tick;
        vecs++;
        if (data_oe !== 1'b1) begin
            errs++;
            $display("FAIL pre_reset_oe: data_oe=%b, expected 1", data_oe);
        end
        #2;
        rst = 1'b1;
        #1;
        vecs++;
        if ({data_oe, int_n, wr_valid, data_out} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
            errs++;
            $display("FAIL reset_mid_read: oe=%b int_n=%b wv=%b dout=%h, expected 0 1 0 0000",
                     data_oe, int_n, wr_valid, data_out);
        end
        cs_n = 1'b1; rd_n = 1'b1;
        repeat (2) tick;
        rst = 1'b0;
        repeat (2) tick;
        host_read(10'h004, 16'h0000);
        host_read(10'h010, 16'h0000);
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_out_of_range;
        test_interrupt;
        test_overlap;
        test_id_reg;
        test_back_to_back;
        test_reset_mid_access;
        repeat (2) tick;
        vecs++;
        if (wq.size() != 0 || rq.size() != 0) begin
            errs++;
            $display("FAIL scoreboard_drain: wq=%0d rq=%0d left, expected 0 0", wq.size(), rq.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
